// File: rtl/bus_pkg.sv
// Shared bus types, default SoC address map and small helpers for the
// registered peripheral crossbar and its address decoder.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } bus_state_e;

    localparam int DEF_N_SLV = 8;

    // Default SoC map; windows are (addr & mask) == base.
    localparam logic [31:0] GPU_BASE    = 32'hFFC0_0000;
    localparam logic [31:0] GPU_MASK    = 32'hFFC0_0000;
    localparam logic [31:0] BIOS_BASE   = 32'hFFFF_F000;
    localparam logic [31:0] BIOS_MASK   = 32'hFFFF_F800;
    localparam logic [31:0] FLASH_BASE  = 32'hFFFF_FC00;
    localparam logic [31:0] FLASH_MASK  = 32'hFFFF_FE00;
    localparam logic [31:0] PERIPH_BASE = 32'hFFFF_FE00;
    localparam logic [31:0] PERIPH_LAST = 32'hFFFF_FE1C;
    localparam logic [31:0] PERIPH_MASK = 32'hFFFF_FFFF;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic window_hit(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] mask);
        return ((addr & mask) == base);
    endfunction

endpackage

// File: rtl/bus_addr_decoder.sv
// Combinational base/mask window compare with a priority encoder; the lowest
// matching slave index wins when windows overlap.
module bus_addr_decoder
    import bus_pkg::*;
#(
    parameter int                  N_SLV    = DEF_N_SLV,
    parameter logic [32*N_SLV-1:0] SLV_BASE = {N_SLV{32'h0000_0000}},
    parameter logic [32*N_SLV-1:0] SLV_MASK = {N_SLV{32'hFFFF_FFFF}}
) (
    input  logic [31:0]                  i_addr,
    output logic                         o_hit,
    output logic [idx_width(N_SLV)-1:0]  o_idx
);

    localparam int IDX_W = idx_width(N_SLV);

    // Scan downwards so a lower-numbered match overwrites any higher one.
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            o_idx = window_hit(i_addr, SLV_BASE[32*i +: 32], SLV_MASK[32*i +: 32])
                    ? IDX_W'(i) : o_idx;
            o_hit = o_hit | window_hit(i_addr, SLV_BASE[32*i +: 32], SLV_MASK[32*i +: 32]);
        end
    end

endmodule

// File: rtl/bus_xbar_reg.sv
// Registered CPU-to-slave crossbar: one access at a time, registered strobes and
// responses, bus error on unmapped, malformed or timed-out accesses.
module bus_xbar_reg
    import bus_pkg::*;
#(
    parameter int                  N_SLV    = DEF_N_SLV,
    parameter logic [32*N_SLV-1:0] SLV_BASE = {N_SLV{32'h0000_0000}},
    parameter logic [32*N_SLV-1:0] SLV_MASK = {N_SLV{32'hFFFF_FFFF}},
    parameter int                  TO_CYC   = 255,
    parameter int                  TO_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           m_addr_i,
    input  logic [31:0]           m_data_i,
    input  logic [1:0]            m_sel_i,
    input  logic                  m_rd_i,
    input  logic                  m_we_i,
    output logic [31:0]           m_data_o,
    output logic                  m_ack_o,
    output logic                  m_err_o,
    output logic [31:0]           s_addr_o,
    output logic [31:0]           s_data_o,
    output logic [1:0]            s_sel_o,
    output logic [N_SLV-1:0]      s_rd_o,
    output logic [N_SLV-1:0]      s_we_o,
    input  logic [32*N_SLV-1:0]   s_data_i,
    input  logic [N_SLV-1:0]      s_ack_i
);

    localparam int              IDX_W   = idx_width(N_SLV);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

    bus_state_e         r_state;
    logic [IDX_W-1:0]   r_idx;
    logic               r_rd;
    logic [TO_W-1:0]    r_cnt;
    logic [N_SLV-1:0]   r_s_rd;
    logic [N_SLV-1:0]   r_s_we;
    logic [31:0]        r_s_addr;
    logic [31:0]        r_s_data;
    logic [1:0]         r_s_sel;
    logic [31:0]        r_m_data;
    logic               r_m_ack;
    logic               r_m_err;

    bus_state_e         w_state_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic               w_rd_nxt;
    logic [TO_W-1:0]    w_cnt_nxt;
    logic [N_SLV-1:0]   w_s_rd_nxt;
    logic [N_SLV-1:0]   w_s_we_nxt;
    logic [31:0]        w_s_addr_nxt;
    logic [31:0]        w_s_data_nxt;
    logic [1:0]         w_s_sel_nxt;
    logic [31:0]        w_m_data_nxt;
    logic               w_m_ack_nxt;
    logic               w_m_err_nxt;

    logic               w_hit;
    logic [IDX_W-1:0]   w_hit_idx;
    logic [N_SLV-1:0]   w_onehot;
    logic               w_req_any;
    logic               w_req_one;
    logic               w_sel_ack;
    logic [31:0]        w_sel_data;

    bus_addr_decoder #(
        .N_SLV    (N_SLV),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_dec (
        .i_addr (m_addr_i),
        .o_hit  (w_hit),
        .o_idx  (w_hit_idx)
    );

    assign w_req_any  = m_rd_i | m_we_i;
    assign w_req_one  = m_rd_i ^ m_we_i;
    assign w_sel_ack  = s_ack_i[r_idx];
    assign w_sel_data = s_data_i[32*r_idx +: 32];

    // One-hot strobe pattern for the decoded slave.
    always_comb begin
        w_onehot            = '0;
        w_onehot[w_hit_idx] = 1'b1;
    end

    // Next-state and next-register values; responses default to idle zero.
    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_rd_nxt     = r_rd;
        w_cnt_nxt    = r_cnt;
        w_s_rd_nxt   = r_s_rd;
        w_s_we_nxt   = r_s_we;
        w_s_addr_nxt = r_s_addr;
        w_s_data_nxt = r_s_data;
        w_s_sel_nxt  = r_s_sel;
        w_m_data_nxt = 32'h0000_0000;
        w_m_ack_nxt  = 1'b0;
        w_m_err_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req_one && w_hit) begin
                    w_idx_nxt    = w_hit_idx;
                    w_rd_nxt     = m_rd_i;
                    w_cnt_nxt    = '0;
                    w_s_rd_nxt   = m_rd_i ? w_onehot : '0;
                    w_s_we_nxt   = m_we_i ? w_onehot : '0;
                    w_s_addr_nxt = m_addr_i;
                    w_s_data_nxt = m_data_i;
                    w_s_sel_nxt  = m_sel_i;
                    w_state_nxt  = ACCESS;
                end else if (w_req_any) begin
                    w_m_ack_nxt = 1'b1;
                    w_m_err_nxt = 1'b1;
                    w_state_nxt = RESP;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ACCESS: begin
                // An ack arriving in the timeout cycle still completes cleanly.
                if (w_sel_ack) begin
                    w_m_data_nxt = r_rd ? w_sel_data : 32'h0000_0000;
                    w_m_ack_nxt  = 1'b1;
                    w_s_rd_nxt   = '0;
                    w_s_we_nxt   = '0;
                    w_state_nxt  = RESP;
                end else if (r_cnt == TO_LAST) begin
                    w_m_ack_nxt = 1'b1;
                    w_m_err_nxt = 1'b1;
                    w_s_rd_nxt  = '0;
                    w_s_we_nxt  = '0;
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = r_cnt + TO_W'(1);
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_rd     <= 1'b0;
            r_cnt    <= '0;
            r_s_rd   <= '0;
            r_s_we   <= '0;
            r_s_addr <= 32'h0000_0000;
            r_s_data <= 32'h0000_0000;
            r_s_sel  <= 2'b00;
            r_m_data <= 32'h0000_0000;
            r_m_ack  <= 1'b0;
            r_m_err  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_rd     <= w_rd_nxt;
            r_cnt    <= w_cnt_nxt;
            r_s_rd   <= w_s_rd_nxt;
            r_s_we   <= w_s_we_nxt;
            r_s_addr <= w_s_addr_nxt;
            r_s_data <= w_s_data_nxt;
            r_s_sel  <= w_s_sel_nxt;
            r_m_data <= w_m_data_nxt;
            r_m_ack  <= w_m_ack_nxt;
            r_m_err  <= w_m_err_nxt;
        end
    end

    assign m_data_o = r_m_data;
    assign m_ack_o  = r_m_ack;
    assign m_err_o  = r_m_err;
    assign s_addr_o = r_s_addr;
    assign s_data_o = r_s_data;
    assign s_sel_o  = r_s_sel;
    assign s_rd_o   = r_s_rd;
    assign s_we_o   = r_s_we;

endmodule

// File: tb/tb_bus_xbar_reg.sv
// Self-checking bench for bus_xbar_reg: directed scenarios plus randomized
// transactions checked cycle by cycle against a transaction-level model.
module tb_bus_xbar_reg;

    localparam int N  = 8;
    localparam int TO = 4;

    // Slave 0 and 2 overlap on 0x2000-0x2FFF; GPU sits last as the catch-all.
    localparam logic [32*N-1:0] P_BASE = {32'hFFC0_0000, 32'hFFFF_FE00, 32'hFFFF_FE08, 32'hFFFF_FC00,
                                          32'hFFFF_FE04, 32'h0000_2000, 32'hFFFF_F000, 32'h0000_2000};
    localparam logic [32*N-1:0] P_MASK = {32'hFFC0_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FE00,
                                          32'hFFFF_FFFF, 32'hFFFF_E000, 32'hFFFF_F800, 32'hFFFF_F000};

    logic            clk      = 1'b0;
    logic            rst      = 1'b0;
    logic [31:0]     m_addr_i = 32'h0;
    logic [31:0]     m_data_i = 32'h0;
    logic [1:0]      m_sel_i  = 2'b00;
    logic            m_rd_i   = 1'b0;
    logic            m_we_i   = 1'b0;
    logic [31:0]     m_data_o;
    logic            m_ack_o;
    logic            m_err_o;
    logic [31:0]     s_addr_o;
    logic [31:0]     s_data_o;
    logic [1:0]      s_sel_o;
    logic [N-1:0]    s_rd_o;
    logic [N-1:0]    s_we_o;
    logic [32*N-1:0] s_data_i = '0;
    logic [N-1:0]    s_ack_i  = '0;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] last_addr = 32'h0;
    logic [31:0] last_data = 32'h0;
    logic [1:0]  last_sel  = 2'b00;

    always #5 clk = ~clk;

    bus_xbar_reg #(
        .N_SLV    (N),
        .SLV_BASE (P_BASE),
        .SLV_MASK (P_MASK),
        .TO_CYC   (TO),
        .TO_W     (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m_addr_i (m_addr_i),
        .m_data_i (m_data_i),
        .m_sel_i  (m_sel_i),
        .m_rd_i   (m_rd_i),
        .m_we_i   (m_we_i),
        .m_data_o (m_data_o),
        .m_ack_o  (m_ack_o),
        .m_err_o  (m_err_o),
        .s_addr_o (s_addr_o),
        .s_data_o (s_data_o),
        .s_sel_o  (s_sel_o),
        .s_rd_o   (s_rd_o),
        .s_we_o   (s_we_o),
        .s_data_i (s_data_i),
        .s_ack_i  (s_ack_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference address map: first window (lowest index) containing the address.
    function automatic void decode(input logic [31:0] a, output bit hit, output int idx);
        hit = 1'b0;
        idx = 0;
        for (int i = 0; i < N; i++) begin
            if (!hit && ((a & P_MASK[32*i +: 32]) == P_BASE[32*i +: 32])) begin
                hit = 1'b1;
                idx = i;
            end
        end
    endfunction

    // One master access. delay = strobe cycles the slave waits before acking
    // (0 = ack in the first strobe cycle); spur = ack noise on other slaves.
    task automatic run_txn(input logic [31:0] addr, input logic rd, input logic we,
                           input logic [1:0] sel, input logic [31:0] wdata,
                           input logic [31:0] rword, input int delay, input logic [N-1:0] spur);
        bit          hit;
        int          tgt;
        bit          bad;
        int          n_strb;
        bit          exp_err;
        logic [31:0] exp_data;
        logic [N-1:0] tbit;
        logic [N-1:0] exp_vec;
        decode(addr, hit, tgt);
        bad      = !hit || (rd == we);
        tbit     = '0;
        if (!bad) tbit[tgt] = 1'b1;
        n_strb   = bad ? 0 : ((delay + 1 > TO) ? TO : delay + 1);
        exp_err  = bad || (delay + 1 > TO);
        exp_data = (rd && !exp_err) ? rword : 32'h0;
        if (!bad) begin
            last_addr = addr;
            last_data = wdata;
            last_sel  = sel;
        end
        m_addr_i = addr;
        m_data_i = wdata;
        m_sel_i  = sel;
        m_rd_i   = rd;
        m_we_i   = we;
        s_ack_i  = spur;
        for (int cyc = 1; cyc <= n_strb + 2; cyc++) begin
            @(negedge clk);
            exp_vec = (cyc <= n_strb) ? tbit : '0;
            check("s_rd_o", 32'(s_rd_o), rd ? 32'(exp_vec) : 32'h0);
            check("s_we_o", 32'(s_we_o), we ? 32'(exp_vec) : 32'h0);
            check("m_ack_o", 32'(m_ack_o), 32'(cyc == n_strb + 1));
            check("m_err_o", 32'(m_err_o), (cyc == n_strb + 1) ? 32'(exp_err) : 32'h0);
            check("m_data_o", m_data_o, (cyc == n_strb + 1) ? exp_data : 32'h0);
            check("s_addr_o", s_addr_o, last_addr);
            check("s_data_o", s_data_o, last_data);
            check("s_sel_o", 32'(s_sel_o), 32'(last_sel));
            if (cyc == 1) begin
                m_addr_i = $urandom;
                m_data_i = $urandom;
                m_sel_i  = 2'($urandom);
            end
            if (cyc <= n_strb) s_ack_i = (spur & ~tbit) | ((cyc == delay + 1) ? tbit : '0);
            else               s_ack_i = spur;
            for (int i = 0; i < N; i++) s_data_i[32*i +: 32] = $urandom;
            if (!bad) s_data_i[32*tgt +: 32] = rword;
        end
    endtask

    task automatic idle(input int n, input logic [N-1:0] ack);
        m_rd_i  = 1'b0;
        m_we_i  = 1'b0;
        s_ack_i = ack;
        repeat (n) begin
            @(negedge clk);
            check("idle_strobe", 32'({s_rd_o, s_we_o}), 32'h0);
            check("idle_ack_err", 32'({m_ack_o, m_err_o}), 32'h0);
            check("idle_mdata", m_data_o, 32'h0);
            check("hold_addr", s_addr_o, last_addr);
            check("hold_data", s_data_o, last_data);
        end
    endtask

    initial begin
        int          s;
        int          k;
        logic [31:0] a;

        repeat (3) @(negedge clk);
        check("rst_s_rd", 32'(s_rd_o), 32'h0);
        check("rst_s_we", 32'(s_we_o), 32'h0);
        check("rst_m_ack", 32'(m_ack_o), 32'h0);
        check("rst_m_err", 32'(m_err_o), 32'h0);
        check("rst_m_data", m_data_o, 32'h0);
        check("rst_s_addr", s_addr_o, 32'h0);
        check("rst_s_data", s_data_o, 32'h0);
        check("rst_s_sel", 32'(s_sel_o), 32'h0);
        rst = 1'b1;
        idle(2, '0);

        // Slow read of slave 3, immediate BIOS write, unmapped read.
        run_txn(32'hFFFF_FE04, 1'b1, 1'b0, 2'b10, 32'h0, 32'h0000_1234, 2, 8'h00);
        run_txn(32'hFFFF_F010, 1'b0, 1'b1, 2'b11, 32'hDEAD_BEEF, 32'h5555_AAAA, 0, 8'h00);
        run_txn(32'h0000_1000, 1'b1, 1'b0, 2'b01, 32'h0, 32'h1111_2222, 0, 8'h00);
        idle(1, '0);
        // Timeout with late acks, then ack exactly in the timeout cycle.
        run_txn(32'hFFFF_FE08, 1'b1, 1'b0, 2'b00, 32'h0, 32'h3333_4444, 99, 8'h20);
        idle(3, 8'h20);
        run_txn(32'hFFFF_FE08, 1'b1, 1'b0, 2'b00, 32'h0, 32'h3434_5656, TO - 1, 8'h00);
        run_txn(32'hFFFF_FC40, 1'b0, 1'b1, 2'b01, 32'h0BAD_F00D, 32'h0, TO, 8'h00);
        // Overlapping windows with a spurious ack from the losing slave.
        run_txn(32'h0000_2100, 1'b1, 1'b0, 2'b10, 32'h0, 32'h7777_0000, 1, 8'h04);
        run_txn(32'h0000_3004, 1'b1, 1'b0, 2'b10, 32'h0, 32'h7777_0002, 0, 8'h01);
        // Read and write together is malformed.
        run_txn(32'hFFFF_FE04, 1'b1, 1'b1, 2'b00, 32'h1, 32'h2, 0, 8'h08);
        idle(1, '0);

        // Reset in the middle of an access.
        m_addr_i = 32'hFFFF_FE00;
        m_rd_i   = 1'b1;
        m_we_i   = 1'b0;
        s_ack_i  = '0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_strobe", 32'(s_rd_o), 32'h0000_0040);
        #2 rst = 1'b0;
        #1;
        check("async_rst_s_rd", 32'(s_rd_o), 32'h0);
        check("async_rst_s_we", 32'(s_we_o), 32'h0);
        check("async_rst_m_ack", 32'(m_ack_o), 32'h0);
        check("async_rst_s_addr", s_addr_o, 32'h0);
        m_rd_i = 1'b0;
        @(negedge clk);
        rst       = 1'b1;
        last_addr = 32'h0;
        last_data = 32'h0;
        last_sel  = 2'b00;
        idle(2, '0);
        run_txn(32'hFFFF_FE00, 1'b1, 1'b0, 2'b11, 32'h0, 32'hCAFE_0006, 1, 8'h00);

        for (int t = 0; t < 300; t++) begin
            s = $urandom_range(0, 9);
            if (s < N) a = P_BASE[32*s +: 32] | ($urandom & ~P_MASK[32*s +: 32]);
            else       a = $urandom & 32'h7FFF_FFFF;
            k = $urandom_range(0, 9);
            run_txn(a, (k <= 5), (k == 0) || (k >= 6), 2'($urandom), $urandom, $urandom,
                    $urandom_range(0, 6), N'($urandom));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2), N'($urandom));
        end
        idle(2, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
